// File: rtl/opb_mcount_snapshot_ctrl.sv
// OPB slave that captures the 64-bit master counter into a coherent MSW/LSW snapshot
// on a sync pulse or a software force, and serves snapshot, control and status words.
module opb_mcount_snapshot_ctrl #(
   parameter logic [31:0] C_BASEADDR   = 32'h01094900,
   parameter logic [31:0] C_HIGHADDR   = 32'h010949FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
   input  logic                        OPB_RNW,
   input  logic                        OPB_select,
   input  logic                        OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
   output logic                        Sl_xferAck,
   output logic                        Sl_errAck,
   output logic                        Sl_retry,
   output logic                        Sl_toutSup,
   input  logic [63:0]                 mcount,
   input  logic                        sync_in,
   output logic                        snap_valid
);

   typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_HOLD} bus_state_t;
   typedef enum logic {CAP_DISARMED, CAP_ARMED} cap_state_t;

   bus_state_t  bus_state_reg;
   cap_state_t  cap_state_reg;

   logic [31:0] rdata_reg;
   logic [31:0] dbus_reg;
   logic        ack_reg;

   logic [31:0] msw_reg;
   logic [31:0] lsw_reg;
   logic        cont_reg;
   logic        valid_reg;
   logic        overrun_reg;
   logic        rd_flag_reg;
   logic [15:0] count_reg;

   // Positional assignment maps OPB bit 31 onto bit 0 of the little-endian view.
   logic [31:0] wdata;
   logic [1:0]  word_off;
   logic        in_range;
   logic        take;
   logic        ctrl_wr;
   logic        arm_wr;
   logic        force_wr;
   logic        clr_wr;
   logic        snap_rd;
   logic        sync_cap;
   logic        capture;
   logic [31:0] status_word;
   logic [31:0] rd_mux;

   assign wdata    = OPB_DBus;
   assign word_off = OPB_ABus[28:29];
   assign in_range = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign take     = (bus_state_reg == BUS_IDLE) && in_range;
   assign ctrl_wr  = take && !OPB_RNW && (word_off == 2'd2) && OPB_BE[3];
   assign arm_wr   = ctrl_wr && wdata[0];
   assign force_wr = ctrl_wr && wdata[1];
   assign clr_wr   = ctrl_wr && wdata[2];
   assign snap_rd  = take && OPB_RNW && !word_off[1];
   assign sync_cap = (cap_state_reg == CAP_ARMED) && sync_in;
   assign capture  = sync_cap || force_wr;

   assign status_word = {count_reg, 13'd0, overrun_reg, valid_reg, cap_state_reg == CAP_ARMED};

   always_comb begin
      rd_mux = 32'd0;
      case (word_off)
         2'd0:    rd_mux = msw_reg;
         2'd1:    rd_mux = lsw_reg;
         2'd2:    rd_mux = {28'd0, cont_reg, 3'd0};
         default: rd_mux = status_word;
      endcase
   end

   // Read data is latched on the accepting edge so a simultaneous capture is not seen.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         bus_state_reg <= BUS_IDLE;
         rdata_reg     <= 32'd0;
         dbus_reg      <= 32'd0;
         ack_reg       <= 1'b0;
      end else begin
         ack_reg  <= 1'b0;
         dbus_reg <= 32'd0;
         case (bus_state_reg)
            BUS_IDLE: begin
               if (take) begin
                  bus_state_reg <= BUS_ACK;
                  rdata_reg     <= OPB_RNW ? rd_mux : 32'd0;
               end
            end
            BUS_ACK: begin
               ack_reg       <= 1'b1;
               dbus_reg      <= rdata_reg;
               bus_state_reg <= BUS_HOLD;
            end
            BUS_HOLD: begin
               if (!OPB_select) bus_state_reg <= BUS_IDLE;
            end
            default: bus_state_reg <= BUS_IDLE;
         endcase
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         cap_state_reg <= CAP_DISARMED;
         cont_reg      <= 1'b0;
         msw_reg       <= 32'd0;
         lsw_reg       <= 32'd0;
         valid_reg     <= 1'b0;
         overrun_reg   <= 1'b0;
         rd_flag_reg   <= 1'b0;
         count_reg     <= 16'd0;
      end else begin
         if (arm_wr)
            cap_state_reg <= CAP_ARMED;
         else if (sync_cap && !cont_reg)
            cap_state_reg <= CAP_DISARMED;

         if (ctrl_wr) cont_reg <= wdata[3];

         if (capture) begin
            msw_reg     <= mcount[63:32];
            lsw_reg     <= mcount[31:0];
            valid_reg   <= 1'b1;
            rd_flag_reg <= 1'b0;
            // A clear in the same cycle restarts the count from this capture.
            if (clr_wr) begin
               count_reg   <= 16'd1;
               overrun_reg <= 1'b0;
            end else begin
               if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
               if (valid_reg && !(rd_flag_reg || snap_rd)) overrun_reg <= 1'b1;
            end
         end else begin
            if (snap_rd) rd_flag_reg <= 1'b1;
            if (clr_wr) begin
               count_reg   <= 16'd0;
               valid_reg   <= 1'b0;
               overrun_reg <= 1'b0;
            end
         end
      end
   end

   assign Sl_DBus    = dbus_reg;
   assign Sl_xferAck = ack_reg;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign snap_valid = valid_reg;

   logic unused_inputs;
   assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:4]};

endmodule

// File: doc/opb_mcount_snapshot_ctrl.md
# opb_mcount_snapshot_ctrl

OPB slave controller that captures a free-running 64-bit master counter (`mcount`) into a coherent MSW/LSW snapshot pair on a sync event and serves it to the PowerPC over OPB. It replaces two independent simulink2ppc registers, which can tear across an LSW carry between reads. It arms one-shot or continuous capture on an external sync pulse, supports a software-forced capture, and reports capture status.

## Interface
- `C_BASEADDR`, 32'h01094900, first byte address of the 16-byte register window.
- `C_HIGHADDR`, 32'h010949FF, last decoded byte address; accesses in range but above offset 0xC alias by word offset.
- `C_OPB_AWIDTH`, 32, OPB address width.
- `C_OPB_DWIDTH`, 32, OPB data width.
- `OPB_Clk`  in  1  sole clock; `mcount` and `sync_in` are synchronous to it.
- `OPB_Rst`  in  1  synchronous, active-high reset.
- `OPB_ABus`  in  [0:31]  address; word offset = `OPB_ABus[28:29]`.
- `OPB_BE`  in  [0:3]  byte enables; `OPB_BE[3]` gates control writes.
- `OPB_DBus`  in  [0:31]  write data; bit 31 is LSB.
- `OPB_RNW`  in  1  1 = read, 0 = write.
- `OPB_select`  in  1  transfer request.
- `OPB_seqAddr`  in  1  ignored.
- `Sl_DBus`  out  [0:31]  read data; zero whenever `Sl_xferAck` is low.
- `Sl_xferAck`  out  1  one-cycle transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup`  out  1  tied 0.
- `mcount`  in  [63:0]  free-running master count.
- `sync_in`  in  1  single-cycle sync pulse.
- `snap_valid`  out  1  high while the snapshot holds a capture.

## Operation
- Register map (word offset):
  - 0: MSW snapshot. Read-only.
  - 1: LSW snapshot. Read-only.
  - 2: CTRL. Read/write.
  - 3: STATUS. Read-only.
  - Writes to read-only offsets are acked and discarded.
- CTRL bits, in LSB numbering (bit 0 = `OPB_DBus[31]`):
  - bit0 ARM: write 1 to arm. Self-clearing.
  - bit1 FORCE: write 1 to capture immediately. Self-clearing.
  - bit2 CLR: write 1 to clear the capture count and `snap_valid`. Self-clearing.
  - bit3 CONT: stored. 1 = continuous mode.
  - CTRL reads return only CONT; all other bits read as 0.
- STATUS bits:
  - bit0 ARMED.
  - bit1 VALID.
  - bit2 OVERRUN: sticky. Set when a capture occurs while VALID=1 and no snapshot read has happened since the previous capture. Cleared by CLR.
  - bits[31:16] capture count: saturates at 0xFFFF.
- Capture FSM states:
  - DISARMED: ARM write → ARMED. FORCE captures from any state and leaves the state unchanged.
  - ARMED: `sync_in`=1 captures. Then → DISARMED if CONT=0, else stay ARMED.
- Capture action:
  - MSW ← `mcount[63:32]`, LSW ← `mcount[31:0]`, both from the same cycle.
  - VALID ← 1, count ← count+1 (saturating).
- Bus FSM states:
  - IDLE: `OPB_select`=1 with address in range → ACK. Read data is registered on this edge. Writes are applied on this edge.
  - ACK: `Sl_xferAck`=1 and `Sl_DBus` driven → HOLD.
  - HOLD: wait for `OPB_select`=0 → IDLE. No ack is issued in HOLD, so a select held high never double-acks.
  - An out-of-range select is ignored (no ack), letting the bus time out.
- Simultaneous events:
  - ARM write and `sync_in` in the same cycle: ARMED takes effect next cycle. No capture.
  - FORCE and `sync_in` while ARMED, same cycle: exactly one capture; count +1.
  - CLR and a capture, same cycle: the capture wins for the snapshot; count = 1, VALID = 1, OVERRUN = 0.
  - Capture on the cycle read data is registered: the read returns the pre-capture value.
- Reset mid-operation: a transfer in ACK or HOLD is abandoned with no ack, and the bus FSM returns to IDLE.

## Timing
- Reset values:
  - `Sl_DBus` = 0, `Sl_xferAck` = 0, `snap_valid` = 0.
  - Snapshot = 0, CTRL = 0, STATUS = 0.
  - Capture FSM = DISARMED, bus FSM = IDLE.
- Read/write latency: `Sl_xferAck` is asserted on the 2nd rising edge after `OPB_select` is first sampled high, for exactly 1 cycle.
- Capture latency: snapshot registers and `snap_valid` update 1 cycle after the `sync_in` or FORCE sample.
- The MSW and LSW held in the snapshot always come from one `mcount` sample, regardless of how the reads are ordered or spaced.

## Test plan
- Reset → all STATUS fields 0. Read of offset 0 acks 2 cycles after select with `Sl_DBus` = 0. `Sl_DBus` = 0 in every non-ack cycle.
- `mcount` = 64'h0000_0001_FFFF_FFFE incrementing; ARM, then `sync_in` at `mcount` = 64'h0000_0001_FFFF_FFFF → after 5 idle cycles, MSW reads 0x00000001 and LSW reads 0xFFFFFFFF; STATUS = 0x0001_0002 (ARMED=0).
- CONT=1 + ARM, then 3 sync pulses 10 cycles apart with no reads → count 3, OVERRUN=1, ARMED=1. CLR → STATUS = 0x0000_0001.
- ARM write in the same cycle as `sync_in` → no capture, ARMED=1. Next `sync_in` → capture, count 1.
- FORCE and `sync_in` in the same cycle while ARMED, CONT=0 → count 1, ARMED=0.
- `OPB_select` held high for 6 cycles → exactly one `Sl_xferAck`. `OPB_Rst` asserted in the ACK state → no ack, bus FSM returns to IDLE, and the next read acks normally.
